// File: rtl/load_store_unit.sv
// Load/store sequencer between the datapath memory request and a word-only dmem
// with one-cycle registered reads; byte stores are done as read-modify-write.
module load_store_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic              is_store;
    logic              is_byte;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rdata;
    logic              fault;

    logic              accept;
    logic              req_misaligned;
    logic [4:0]        lane_bit;
    logic [7:0]        lane_byte;
    logic [DATA_W-1:0] merge_word;

    assign accept         = req_valid && (state == IDLE);
    assign req_misaligned = !req_byte && (req_addr[1:0] != 2'b00);
    assign lane_bit       = {addr[1:0], 3'b000};

    // Lane extraction for byte loads and lane replacement for byte stores.
    always_comb begin
        lane_byte  = mem_rd[lane_bit +: 8];
        merge_word = mem_rd;
        merge_word[lane_bit +: 8] = wdata[7:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_misaligned)
                        state_next = RESP;
                    else if (req_we && !req_byte)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:  state_next = WAIT;
            WAIT:  state_next = is_store ? WRITE : RESP;
            WRITE: state_next = RESP;
            RESP:  state_next = resp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            is_store <= 1'b0;
            is_byte  <= 1'b0;
            wdata    <= '0;
            merged   <= '0;
            rdata    <= '0;
            fault    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr     <= req_addr;
                is_store <= req_we;
                is_byte  <= req_byte;
                wdata    <= req_wdata;
                rdata    <= '0;
                fault    <= req_misaligned;
            end
            // mem_rd holds the word addressed during READ.
            if (state == WAIT) begin
                if (is_store)
                    merged <= merge_word;
                else if (is_byte)
                    rdata <= {{(DATA_W-8){1'b0}}, lane_byte};
                else
                    rdata <= mem_rd;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata;
    assign resp_fault = fault;
    assign mem_a      = {addr[ADDR_W-1:2], 2'b00};
    // Gated by reset so a write cannot commit on the edge that aborts it.
    assign mem_we     = (state == WRITE) && !reset;
    assign mem_wd     = (state == WRITE) ? (is_byte ? merged : wdata) : '0;

endmodule
